// File: rtl/serial_adsub_pkg.sv
// serial_adsub_pkg: shared FSM state type and op encodings for the bit-serial adder/subtractor
package serial_adsub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_adsub_ctrl_cell.sv
// full_adsub_cell: one-bit full add/sub from two half add/sub stages; in a, b, cin, op; out s, cout (carry or borrow)
module full_adsub_cell
  import serial_adsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);
  logic x, c1, c2;
  assign x    = a ^ b;
  assign c1   = (op == OP_SUB ? ~a : a) & b;
  assign s    = x ^ cin;
  assign c2   = (op == OP_SUB ? ~x : x) & cin;
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adsub_ctrl.sv
// serial_adsub_ctrl: LSB-first bit-serial WIDTH-bit add/sub; in clk, rst, start, op, a_in, b_in; out busy, done, result, cout, ovf (only with SERIAL_ADSUB_OVF_EN)
module serial_adsub_ctrl
  import serial_adsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADSUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic op_r, carry, s, c_n;
  full_adsub_cell u_cell (
    .a   (a_r[0]),
    .b   (b_r[0]),
    .cin (carry),
    .op  (op_r),
    .s   (s),
    .cout(c_n)
  );
  always_comb begin
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == LAST ? DONE : SHIFT) : IDLE;
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_r   <= a_in;
        b_r   <= b_in;
        op_r  <= op;
        cnt   <= '0;
        carry <= 1'b0;
      end else if (state == SHIFT) begin
        a_r    <= a_r >> 1;
        b_r    <= b_r >> 1;
        carry  <= c_n;
        cnt    <= cnt + 1'b1;
        result <= {s, result[WIDTH-1:1]};
        if (cnt == LAST) begin
          cout <= c_n;
`ifdef SERIAL_ADSUB_OVF_EN
          // a_r[0]/b_r[0] hold the operand sign bits here and s is the result sign bit
          ovf  <= (s != a_r[0]) && ((a_r[0] ^ b_r[0]) == (op_r == OP_SUB));
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adsub_ctrl.sv
// tb_serial_adsub_ctrl: randomized and directed checks of serial_adsub_ctrl against an arithmetic timeline model
module tb_serial_adsub_ctrl;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0, op = 0;
  logic [W-1:0] a_in = 0, b_in = 0, result;
  logic busy, done, cout;
`ifdef SERIAL_ADSUB_OVF_EN
  logic ovf;
`endif
  int tests = 0, fails = 0;

  serial_adsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef SERIAL_ADSUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int n = 0, k = -1000, sa, sb, sv, cd;
  logic [W-1:0] pr = 0, held = 0;
  logic [W:0] t;
  logic pc = 0, po = 0, hc = 0, ho = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = -1000;
      held = '0;
      hc = 0;
      ho = 0;
    end else begin
      n++;
      if (n - k == W) begin
        held = pr;
        hc = pc;
        ho = po;
      end
      if (start && n - k >= W + 2) begin
        k = n;
        sa = $signed(a_in);
        sb = $signed(b_in);
        if (op) begin
          pr = a_in - b_in;
          pc = a_in < b_in;
          sv = sa - sb;
        end else begin
          t = {1'b0, a_in} + {1'b0, b_in};
          pr = t[W-1:0];
          pc = t[W];
          sv = sa + sb;
        end
        po = sv > (2 ** (W - 1)) - 1 || sv < -(2 ** (W - 1));
      end
    end
  end

  always @(negedge clk) begin
    cd = n - k;
    chk("busy", busy, cd >= 0 && cd < W);
    chk("done", done, cd == W);
    if (!(cd >= 0 && cd < W)) begin
      chk("result", result, held);
      chk("cout", cout, hc);
`ifdef SERIAL_ADSUB_OVF_EN
      chk("ovf", ovf, ho);
`endif
    end
  end

  int lat, bc, dc;

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o, input bit noise);
    @(negedge clk);
    a_in = a; b_in = b; op = o; start = 1;
    @(negedge clk);
    start = 0; a_in = W'($urandom); b_in = W'($urandom); op = 1'($urandom);
    lat = 0; bc = 0; dc = 0;
    for (int i = 1; i <= W + 6; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (lat == 0) lat = i;
      end
      if (noise && i == 3) begin
        start = 1; a_in = W'($urandom); b_in = W'($urandom); op = 1'($urandom);
      end else start = 0;
      @(negedge clk);
    end
    chk("latency", lat, W + 1);
    chk("busy_cycles", bc, W);
    chk("done_count", dc, 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic o, input bit noise,
                     input logic [W-1:0] er, input logic ec);
    do_op(a, b, o, noise);
    chk("lit_result", result, er);
    chk("lit_cout", cout, ec);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    run(8'h0F, 8'h01, 0, 0, 8'h10, 0);
    run(8'hFF, 8'h01, 0, 0, 8'h00, 1);
    run(8'h05, 8'h03, 1, 0, 8'h02, 0);
    run(8'h03, 8'h05, 1, 0, 8'hFE, 1);
    run(8'h3C, 8'h21, 0, 1, 8'h5D, 0);
`ifdef SERIAL_ADSUB_OVF_EN
    run(8'h7F, 8'h01, 0, 0, 8'h80, 0);
    chk("lit_ovf_add", ovf, 1);
    run(8'h80, 8'h01, 1, 0, 8'h7F, 0);
    chk("lit_ovf_sub", ovf, 1);
    run(8'h01, 8'h01, 0, 0, 8'h02, 0);
    chk("lit_ovf_none", ovf, 0);
`endif
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h11; op = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    #2 rst = 0;
    dc = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("no_done_after_rst", dc, 0);
    for (int j = 0; j < 40; j++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
